dsram_bus_bridge: RTL and testbench

- Sits directly downstream of the CPU core's data SRAM port (data_sram_en/wen/addr/wdata/rdata).
- Converts the core's single-cycle SRAM-style access into a valid/ready request plus response-valid bus transaction.
- Raises a stall request to the core while a transaction is outstanding; the core feeds that request into CTRL alongside its load and EX stall requests.
- Includes a response watchdog so a hung bus cannot deadlock the pipeline.

---
 rtl/dsram_bus_bridge_pkg.sv | 20 ++
 rtl/dsram_bus_bridge_watchdog.sv | 24 ++
 rtl/dsram_bus_bridge.sv | 119 +++++++++++
 tb/tb_dsram_bus_bridge.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dsram_bus_bridge_pkg.sv
// Shared types and constants for the data-SRAM to valid/ready bus bridge.
package dsram_bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_t;

  localparam logic [31:0] DSRAM_BRIDGE_ERR_RDATA = 32'hDEAD_BEEF;

  // Slot of stallreq_for_bus in CTRL's stall request list (after rst, load, ex).
  localparam int STALL_IDX_BUS = 3;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dsram_bus_bridge_watchdog.sv
// Response watchdog: counts cycles while enabled and flags expiry at TIMEOUT_CYC.
module bus_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  // cnt holds cycles already spent, so expiry lands on the TIMEOUT_CYC-th cycle.
  assign expire = (TIMEOUT_CYC != 0) && en && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dsram_bus_bridge.sv
// Data-SRAM port to valid/ready bus bridge with stall request and response watchdog.
// Optional posted writes: define DSRAM_WR_POST_EN.
module dsram_bus_bridge
  import dsram_bus_bridge_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA   = DSRAM_BRIDGE_ERR_RDATA
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_sram_en,
  input  logic [DATA_W/8-1:0] data_sram_wen,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic [DATA_W-1:0]   data_sram_rdata,
  output logic                stallreq_for_bus,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic                bus_req_we,
  output logic [DATA_W/8-1:0] bus_req_wstrb,
  output logic [ADDR_W-1:0]   bus_req_addr,
  output logic [DATA_W-1:0]   bus_req_wdata,
  input  logic                bus_resp_valid,
  input  logic [DATA_W-1:0]   bus_resp_rdata,
  output logic                bus_err
);
  localparam int STRB_W = strb_w(DATA_W);

`ifdef DSRAM_WR_POST_EN
  localparam bit POST_EN = 1'b1;
`else
  localparam bit POST_EN = 1'b0;
`endif

  bridge_state_t       state, state_nxt;
  logic [STRB_W-1:0]   req_wstrb;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                posted;
  logic                expire, accept, resp_done, new_is_post;

  assign accept      = (state == ST_IDLE) && data_sram_en;
  assign new_is_post = POST_EN && (|data_sram_wen);
  assign resp_done   = (state == ST_RESP) && (bus_resp_valid || expire);

  bus_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state == ST_REQ) && bus_req_ready),
    .en     (state == ST_RESP),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (data_sram_en)  state_nxt = ST_REQ;
      ST_REQ:  if (bus_req_ready) state_nxt = ST_RESP;
      ST_RESP: if (bus_resp_valid || expire) state_nxt = posted ? ST_IDLE : ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A posted write only stalls the core when the core tries another access.
  always_comb begin
    stallreq_for_bus = 1'b0;
    bus_req_valid    = 1'b0;
    case (state)
      ST_IDLE: stallreq_for_bus = data_sram_en && !new_is_post;
      ST_REQ:  begin
        stallreq_for_bus = !posted || data_sram_en;
        bus_req_valid    = 1'b1;
      end
      ST_RESP: stallreq_for_bus = !posted || data_sram_en;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_wstrb <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      posted    <= 1'b0;
    end else if (accept) begin
      req_wstrb <= data_sram_wen;
      req_addr  <= data_sram_addr;
      req_wdata <= data_sram_wdata;
      posted    <= new_is_post;
    end
  end

  // A response in the expiry cycle wins over the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sram_rdata <= '0;
      bus_err         <= 1'b0;
    end else begin
      bus_err <= resp_done && !bus_resp_valid;
      if (resp_done && bus_resp_valid && (req_wstrb == '0))
        data_sram_rdata <= bus_resp_rdata;
      else if (resp_done && !bus_resp_valid && !posted)
        data_sram_rdata <= ERR_RDATA;
    end
  end

  assign bus_req_we    = |req_wstrb;
  assign bus_req_wstrb = req_wstrb;
  assign bus_req_addr  = req_addr;
  assign bus_req_wdata = req_wdata;

endmodule

// File: tb/tb_dsram_bus_bridge.sv
// Directed bench for dsram_bus_bridge (TIMEOUT_CYC=4); inputs change 1ns after posedge.
module tb_dsram_bus_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr, wdata, rdata;
  logic        stall, req_valid, req_ready, req_we;
  logic [3:0]  req_wstrb;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dsram_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_sram_en     (en),
    .data_sram_wen    (wen),
    .data_sram_addr   (addr),
    .data_sram_wdata  (wdata),
    .data_sram_rdata  (rdata),
    .stallreq_for_bus (stall),
    .bus_req_valid    (req_valid),
    .bus_req_ready    (req_ready),
    .bus_req_we       (req_we),
    .bus_req_wstrb    (req_wstrb),
    .bus_req_addr     (req_addr),
    .bus_req_wdata    (req_wdata),
    .bus_resp_valid   (resp_valid),
    .bus_resp_rdata   (resp_rdata),
    .bus_err          (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wen = '0; addr = '0; wdata = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    tick; tick;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_err",   {31'b0, err}, 32'd0);
    rst = 1'b0;
    tick;

    // Read, zero-wait slave
    en = 1'b1; wen = 4'b0000; addr = 32'h100; settle;
    chk("rd_idle_stall", {31'b0, stall}, 32'd1);
    chk("rd_idle_valid", {31'b0, req_valid}, 32'd0);
    tick; req_ready = 1'b1; settle;
    chk("rd_req_valid", {31'b0, req_valid}, 32'd1);
    chk("rd_req_addr", req_addr, 32'h100);
    chk("rd_req_we", {31'b0, req_we}, 32'd0);
    chk("rd_req_stall", {31'b0, stall}, 32'd1);
    tick; req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h1234_5678; settle;
    chk("rd_resp_valid", {31'b0, req_valid}, 32'd0);
    chk("rd_resp_stall", {31'b0, stall}, 32'd1);
    tick; resp_valid = 1'b0; en = 1'b0; settle;
    chk("rd_done_rdata", rdata, 32'h1234_5678);
    chk("rd_done_stall", {31'b0, stall}, 32'd0);
    tick;
    chk("rd_idle_hold", rdata, 32'h1234_5678);

    // Write with 3 cycles of ready backpressure
    en = 1'b1; wen = 4'b0011; addr = 32'h200; wdata = 32'hAABB_CCDD; settle;
    chk("wr_idle_stall", {31'b0, stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("wr_bp_valid", {31'b0, req_valid}, 32'd1);
      chk("wr_bp_wstrb", {28'b0, req_wstrb}, 32'h3);
      chk("wr_bp_wdata", req_wdata, 32'hAABB_CCDD);
      chk("wr_bp_addr",  req_addr, 32'h200);
      chk("wr_bp_we",    {31'b0, req_we}, 32'd1);
      chk("wr_bp_stall", {31'b0, stall}, 32'd1);
    end
    tick; // still REQ, raise ready
    req_ready = 1'b1; settle;
    tick; req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h5555_5555; settle;
    chk("wr_resp_stall", {31'b0, stall}, 32'd1);
    tick; resp_valid = 1'b0; en = 1'b0; wen = '0; settle;
    chk("wr_done_stall", {31'b0, stall}, 32'd0);
    chk("wr_keeps_rdata", rdata, 32'h1234_5678);
    tick;

    // Watchdog timeout, no response
    en = 1'b1; addr = 32'h300; tick; req_ready = 1'b1;
    tick; req_ready = 1'b0; // RESP cycle 1
    tick; tick; tick; settle; // RESP cycle 4
    chk("to_last_stall", {31'b0, stall}, 32'd1);
    chk("to_last_err", {31'b0, err}, 32'd0);
    tick; en = 1'b0; settle;
    chk("to_done_rdata", rdata, 32'hDEAD_BEEF);
    chk("to_done_err", {31'b0, err}, 32'd1);
    chk("to_done_stall", {31'b0, stall}, 32'd0);
    tick;
    chk("to_err_pulse", {31'b0, err}, 32'd0);

    // Response in the expiry cycle takes priority
    en = 1'b1; addr = 32'h310; tick; req_ready = 1'b1;
    tick; req_ready = 1'b0;
    tick; tick; tick; resp_valid = 1'b1; resp_rdata = 32'h0BAD_F00D;
    tick; resp_valid = 1'b0; en = 1'b0; settle;
    chk("tie_rdata", rdata, 32'h0BAD_F00D);
    chk("tie_no_err", {31'b0, err}, 32'd0);
    tick;

    // Reset mid-RESP, late response ignored
    en = 1'b1; addr = 32'h400; tick; req_ready = 1'b1;
    tick; req_ready = 1'b0; en = 1'b0;
    rst = 1'b1; settle;
    chk("mrst_rdata", rdata, 32'h0);
    chk("mrst_stall", {31'b0, stall}, 32'd0);
    chk("mrst_valid", {31'b0, req_valid}, 32'd0);
    chk("mrst_addr", req_addr, 32'h0);
    tick; rst = 1'b0;
    tick; resp_valid = 1'b1; resp_rdata = 32'hFFFF_0000;
    tick; resp_valid = 1'b0; settle;
    chk("mrst_ignored", rdata, 32'h0);
    chk("mrst_no_valid", {31'b0, req_valid}, 32'd0);
    en = 1'b1; addr = 32'h480; tick; req_ready = 1'b1; settle;
    chk("mrst_fresh_valid", {31'b0, req_valid}, 32'd1);
    chk("mrst_fresh_addr", req_addr, 32'h480);
    tick; req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h0000_0480;
    tick; resp_valid = 1'b0; en = 1'b0; settle;
    chk("mrst_fresh_rdata", rdata, 32'h0000_0480);
    tick;

    // Back-to-back accesses with en held high
    en = 1'b1; addr = 32'h500; tick; req_ready = 1'b1;
    tick; req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'hA5A5_0001;
    tick; resp_valid = 1'b0; addr = 32'h504; settle; // DONE, core moves on
    chk("b2b_done_valid", {31'b0, req_valid}, 32'd0);
    chk("b2b_done_stall", {31'b0, stall}, 32'd0);
    chk("b2b_first_rdata", rdata, 32'hA5A5_0001);
    tick;
    chk("b2b_idle_valid", {31'b0, req_valid}, 32'd0);
    chk("b2b_idle_stall", {31'b0, stall}, 32'd1);
    tick; req_ready = 1'b1; settle;
    chk("b2b_req2_valid", {31'b0, req_valid}, 32'd1);
    chk("b2b_req2_addr", req_addr, 32'h504);
    tick; req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'hA5A5_0002;
    tick; resp_valid = 1'b0; en = 1'b0; settle;
    chk("b2b_second_rdata", rdata, 32'hA5A5_0002);
    tick;

`ifdef DSRAM_WR_POST_EN
    // Posted write followed by a read of the same address
    en = 1'b1; wen = 4'b1111; addr = 32'h600; wdata = 32'h1111_2222; settle;
    chk("pw_idle_stall", {31'b0, stall}, 32'd0);
    tick; wen = 4'b0000; settle; // core now issues the read
    chk("pw_req_valid", {31'b0, req_valid}, 32'd1);
    chk("pw_req_we", {31'b0, req_we}, 32'd1);
    chk("pw_rd_stall", {31'b0, stall}, 32'd1);
    req_ready = 1'b1;
    tick; req_ready = 1'b0; resp_valid = 1'b1; settle;
    chk("pw_resp_stall", {31'b0, stall}, 32'd1);
    tick; resp_valid = 1'b0; settle; // back to IDLE, read handled now
    chk("pw_idle2_stall", {31'b0, stall}, 32'd1);
    chk("pw_idle2_valid", {31'b0, req_valid}, 32'd0);
    tick; req_ready = 1'b1; settle;
    chk("pw_rd_valid", {31'b0, req_valid}, 32'd1);
    chk("pw_rd_we", {31'b0, req_we}, 32'd0);
    tick; req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h1111_2222;
    tick; resp_valid = 1'b0; en = 1'b0; settle;
    chk("pw_rd_rdata", rdata, 32'h1111_2222);
    chk("pw_rd_done_stall", {31'b0, stall}, 32'd0);
    tick;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
